imm_gen_pipe: RTL and testbench

Registered, parametrised immediate generator for the decode stage. Extracts and extends the immediate for every RV32I/RV64I format, not just I/S/B. A valid/ready skid buffer lets it sit between fetch and execute under back-pressure without a combinational ready path. Codes 0-2 keep the existing ImmSrc encoding (I, S, B).

---
 rtl/imm_pkg.sv | 25 ++
 rtl/imm_format.sv | 40 ++++
 rtl/imm_gen_pipe.sv | 88 ++++++++
 tb/tb_imm_gen_pipe.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imm_pkg                                                              |
// | Shared format codes and widths for the immediate generator.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package imm_pkg;

    localparam int SRC_W  = 3;
    localparam int XLEN32 = 32;
    localparam int XLEN64 = 64;

    typedef enum logic [SRC_W-1:0] {
        IMM_I     = 3'd0,
        IMM_S     = 3'd1,
        IMM_B     = 3'd2,
        IMM_U     = 3'd3,
        IMM_J     = 3'd4,
        IMM_SHAMT = 3'd5,
        IMM_ZIMM  = 3'd6,
        IMM_RSVD  = 3'd7
    } imm_src_e;

endpackage
`default_nettype wire

// File: rtl/imm_format.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imm_format                                                           |
// | Combinational immediate extraction and extension for RV32I/RV64I.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module imm_format #(
    parameter int XLEN = imm_pkg::XLEN32
) (
    input  logic [31:0]               inst,
    input  logic [imm_pkg::SRC_W-1:0] src,
    output logic [XLEN-1:0]           imm,
    output logic                      illegal
);
    import imm_pkg::*;

    // Opcode/rd-low bits never feed any immediate.
    logic w_unused_opcode;
    assign w_unused_opcode = ^inst[6:0];

    always_comb begin
        imm     = '0;
        illegal = 1'b0;
        case (imm_src_e'(src))
            IMM_I:     imm = XLEN'($signed(inst[31:20]));
            IMM_S:     imm = XLEN'($signed({inst[31:25], inst[11:7]}));
            IMM_B:     imm = XLEN'($signed({inst[31], inst[7], inst[30:25],
                                            inst[11:8], 1'b0}));
            IMM_U:     imm = XLEN'($signed({inst[31:12], 12'b0}));
            IMM_J:     imm = XLEN'($signed({inst[31], inst[19:12], inst[20],
                                            inst[30:21], 1'b0}));
            IMM_SHAMT: imm = (XLEN == XLEN64) ? XLEN'(inst[25:20])
                                              : XLEN'(inst[24:20]);
            IMM_ZIMM:  imm = XLEN'(inst[19:15]);
            default:   illegal = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/imm_gen_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imm_gen_pipe                                                         |
// | Registered immediate generator behind a valid/ready skid buffer.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module imm_gen_pipe #(
    parameter int XLEN  = imm_pkg::XLEN32,
    parameter int SRC_W = imm_pkg::SRC_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [SRC_W-1:0] in_imm_src,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic             out_illegal
);
    import imm_pkg::*;

    generate
        if (XLEN != XLEN32 && XLEN != XLEN64) begin : g_bad_xlen
            $error("imm_gen_pipe: XLEN must be 32 or 64");
        end
        if (SRC_W != imm_pkg::SRC_W) begin : g_bad_src_w
            $error("imm_gen_pipe: SRC_W must match imm_pkg::SRC_W");
        end
    endgenerate

    logic [XLEN-1:0] w_new_imm;
    logic            w_new_illegal;
    logic            w_accept;

    logic            r_out_valid;
    logic [XLEN-1:0] r_out_imm;
    logic            r_out_illegal;
    logic            r_skid_valid;
    logic [XLEN-1:0] r_skid_imm;
    logic            r_skid_illegal;

    imm_format #(.XLEN(XLEN)) u_format (
        .inst    (in_inst),
        .src     (in_imm_src),
        .imm     (w_new_imm),
        .illegal (w_new_illegal)
    );

    // Ready depends on state only, so no ready path crosses the block.
    assign in_ready    = !r_skid_valid;
    assign w_accept    = in_valid && !r_skid_valid;
    assign out_valid   = r_out_valid;
    assign out_imm     = r_out_imm;
    assign out_illegal = r_out_illegal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid    <= 1'b0;
            r_out_imm      <= '0;
            r_out_illegal  <= 1'b0;
            r_skid_valid   <= 1'b0;
            r_skid_imm     <= '0;
            r_skid_illegal <= 1'b0;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (r_skid_valid && out_ready) begin
            r_out_imm     <= r_skid_imm;
            r_out_illegal <= r_skid_illegal;
            r_skid_valid  <= 1'b0;
        end else if (w_accept && (!r_out_valid || out_ready)) begin
            r_out_valid   <= 1'b1;
            r_out_imm     <= w_new_imm;
            r_out_illegal <= w_new_illegal;
        end else if (w_accept) begin
            r_skid_valid   <= 1'b1;
            r_skid_imm     <= w_new_imm;
            r_skid_illegal <= w_new_illegal;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_imm_gen_pipe                                                      |
// | Directed and random checks of imm_gen_pipe at XLEN 32 and 64.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_inst = '0;
    logic [2:0]  in_imm_src = '0;
    logic        out_ready = 1'b0;

    logic        in_ready32, out_valid32, out_illegal32;
    logic [31:0] out_imm32;
    logic        in_ready64, out_valid64, out_illegal64;
    logic [63:0] out_imm64;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .SRC_W(3)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32),
        .in_inst(in_inst), .in_imm_src(in_imm_src),
        .out_valid(out_valid32), .out_ready(out_ready),
        .out_imm(out_imm32), .out_illegal(out_illegal32)
    );

    imm_gen_pipe #(.XLEN(64), .SRC_W(3)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64),
        .in_inst(in_inst), .in_imm_src(in_imm_src),
        .out_valid(out_valid64), .out_ready(out_ready),
        .out_imm(out_imm64), .out_illegal(out_illegal64)
    );

    typedef struct {
        logic [31:0] inst;
        logic [2:0]  src;
        logic [31:0] exp32;
        logic [63:0] exp64;
        logic        exp_ill;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: build a 64-bit value from the field layout, narrow for RV32.
    function automatic logic [63:0] ref_imm(input logic [31:0] i, input logic [2:0] s, input int xlen);
        logic [63:0] v;
        case (s)
            3'd0: v = {{52{i[31]}}, i[31:20]};
            3'd1: v = {{52{i[31]}}, i[31:25], i[11:7]};
            3'd2: v = {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            3'd3: v = {{32{i[31]}}, i[31:12], 12'h000};
            3'd4: v = {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            3'd5: v = (xlen == 64) ? {58'd0, i[25:20]} : {59'd0, i[24:20]};
            3'd6: v = {59'd0, i[19:15]};
            default: v = 64'd0;
        endcase
        if (xlen == 32) v = {32'd0, v[31:0]};
        return v;
    endfunction

    task automatic check_both(input string name, input logic [31:0] e32, input logic [63:0] e64, input logic eill);
        check({name, " valid32"}, {63'd0, out_valid32}, 64'd1);
        check({name, " valid64"}, {63'd0, out_valid64}, 64'd1);
        check({name, " imm32"}, {32'd0, out_imm32}, {32'd0, e32});
        check({name, " imm64"}, out_imm64, e64);
        check({name, " ill32"}, {63'd0, out_illegal32}, {63'd0, eill});
        check({name, " ill64"}, {63'd0, out_illegal64}, {63'd0, eill});
    endtask

    task automatic offer(input logic [31:0] i, input logic [2:0] s);
        in_valid   = 1'b1;
        in_inst    = i;
        in_imm_src = s;
    endtask

    vec_t vecs[14];

    initial begin
        vecs[0]  = '{32'hFFF00093, 3'd0, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0};
        vecs[1]  = '{32'h7FF00093, 3'd0, 32'h000007FF, 64'h00000000000007FF, 1'b0};
        vecs[2]  = '{32'h00112423, 3'd1, 32'h00000008, 64'h0000000000000008, 1'b0};
        vecs[3]  = '{32'hFE112E23, 3'd1, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};
        vecs[4]  = '{32'hFE000EE3, 3'd2, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};
        vecs[5]  = '{32'h123450B7, 3'd3, 32'h12345000, 64'h0000000012345000, 1'b0};
        vecs[6]  = '{32'hFFFFF037, 3'd3, 32'hFFFFF000, 64'hFFFFFFFFFFFFF000, 1'b0};
        vecs[7]  = '{32'h800000EF, 3'd4, 32'hFFF00000, 64'hFFFFFFFFFFF00000, 1'b0};
        vecs[8]  = '{32'h0080006F, 3'd4, 32'h00000008, 64'h0000000000000008, 1'b0};
        vecs[9]  = '{32'h03F01013, 3'd5, 32'h0000001F, 64'h000000000000003F, 1'b0};
        vecs[10] = '{32'hFFFFFFFF, 3'd5, 32'h0000001F, 64'h000000000000003F, 1'b0};
        vecs[11] = '{32'hFFFFFFFF, 3'd6, 32'h0000001F, 64'h000000000000001F, 1'b0};
        vecs[12] = '{32'hDEADBEEF, 3'd7, 32'h00000000, 64'h0000000000000000, 1'b1};
        vecs[13] = '{32'h00000000, 3'd7, 32'h00000000, 64'h0000000000000000, 1'b1};

        // Reset state
        #1;
        check("rst in_ready", {63'd0, in_ready32}, 64'd1);
        check("rst out_valid", {63'd0, out_valid32}, 64'd0);
        check("rst out_imm64", out_imm64, 64'd0);
        step();
        rst_n = 1'b1;
        step();

        // Table: one vector per cycle with out_ready high
        out_ready = 1'b1;
        for (int k = 0; k < 14; k++) begin
            offer(vecs[k].inst, vecs[k].src);
            step();
            check_both($sformatf("vec%0d", k), vecs[k].exp32, vecs[k].exp64, vecs[k].exp_ill);
        end
        in_valid = 1'b0;
        step();
        check("drain valid", {63'd0, out_valid32}, 64'd0);

        // Back-pressure: A, B, C offered while stalled
        out_ready = 1'b0;
        offer(32'h00100093, 3'd0);
        step();
        check("bp A main", {32'd0, out_imm32}, 64'd1);
        check("bp ready after A", {63'd0, in_ready32}, 64'd1);
        offer(32'h00200093, 3'd0);
        step();
        check("bp ready after B", {63'd0, in_ready32}, 64'd0);
        check("bp ready64 after B", {63'd0, in_ready64}, 64'd0);
        offer(32'h00300093, 3'd0);
        for (int k = 0; k < 2; k++) begin
            step();
            check("bp stall imm", {32'd0, out_imm32}, 64'd1);
            check("bp stall valid", {63'd0, out_valid32}, 64'd1);
            check("bp stall ready", {63'd0, in_ready32}, 64'd0);
        end
        out_ready = 1'b1;
        step();
        check("bp out B", {32'd0, out_imm32}, 64'd2);
        check("bp ready restored", {63'd0, in_ready32}, 64'd1);
        step();
        check("bp out C", out_imm64, 64'd3);
        check("bp C valid", {63'd0, out_valid64}, 64'd1);
        in_valid = 1'b0;
        step();
        check("bp empty", {63'd0, out_valid32}, 64'd0);

        // Flush with both entries held and a word on the input
        out_ready = 1'b0;
        offer(32'h00100093, 3'd0);
        step();
        offer(32'h00200093, 3'd0);
        step();
        offer(32'h00500093, 3'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush valid", {63'd0, out_valid32}, 64'd0);
        check("flush ready", {63'd0, in_ready32}, 64'd1);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("flush no output", {63'd0, out_valid64}, 64'd0);
        end

        // Flush with only main held: the word accepted alongside is dropped
        out_ready = 1'b0;
        offer(32'h00100093, 3'd0);
        step();
        offer(32'h00600093, 3'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        check("flush drop valid", {63'd0, out_valid32}, 64'd0);

        // Asynchronous reset mid-cycle with both entries held
        out_ready = 1'b0;
        offer(32'hDEADBEEF, 3'd7);
        step();
        offer(32'hFFF00093, 3'd0);
        step();
        check("pre-rst ill", {63'd0, out_illegal32}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst valid", {63'd0, out_valid32}, 64'd0);
        check("arst imm64", out_imm64, 64'd0);
        check("arst ill", {63'd0, out_illegal64}, 64'd0);
        check("arst ready", {63'd0, in_ready32}, 64'd1);
        in_valid = 1'b0;
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        check("post-rst valid", {63'd0, out_valid32}, 64'd0);

        // Streaming: random pairs, one result per cycle, skid never used
        for (int k = 0; k < 100; k++) begin
            logic [31:0] ri;
            logic [2:0]  rs;
            ri = $urandom;
            rs = 3'($urandom_range(0, 7));
            offer(ri, rs);
            step();
            check($sformatf("str%0d imm32", k), {32'd0, out_imm32}, ref_imm(ri, rs, 32));
            check($sformatf("str%0d imm64", k), out_imm64, ref_imm(ri, rs, 64));
            check($sformatf("str%0d ill", k), {63'd0, out_illegal32}, {63'd0, (rs == 3'd7)});
            check($sformatf("str%0d valid", k), {63'd0, out_valid32}, 64'd1);
            check($sformatf("str%0d ready", k), {63'd0, in_ready32}, 64'd1);
        end
        in_valid = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
